scmp_ifetch: RTL and testbench

Instruction fetch unit for the SC/MP core. On a request from the microcode sequencer it reads the opcode byte at the pre-incremented program counter. For two-byte instructions it also reads the displacement/immediate byte. It then presents the opcode, operand and updated PC to the sequencer, which uses the opcode to select its microcode entry point. It sits between the sequencer and the external memory bus interface.

---
 rtl/scmp_ifetch.sv | 114 +++++++++++
 tb/tb_scmp_ifetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_ifetch.sv
// SC/MP instruction fetch: reads opcode (and displacement for two-byte ops)
// at the pre-incremented PC and hands op/disp/updated PC to the sequencer.
module scmp_ifetch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] pc_in,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  op,
   output logic [7:0]  disp,
   output logic        op_two,
   output logic [15:0] pc_out,
   output logic        pc_we,
   output logic        op_valid,
   output logic        busy
);

   localparam int unsigned AW     = 16;
   localparam int unsigned DW     = 8;
   localparam int unsigned PAGE_W = 12;

   typedef enum logic [1:0] {
      IDLE,
      FETCH_OP,
      FETCH_DISP,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_d, pc_d;
   logic [DW-1:0]   op_d, disp_d;
   logic            two_d;
   logic            req_d, busy_d, done_d;

   // PC increment wraps inside the 4 KB page; carry out of bit 11 is dropped
   function automatic logic [AW-1:0] inc12(input logic [AW-1:0] a);
      return {a[AW-1:PAGE_W], PAGE_W'(a[PAGE_W-1:0] + PAGE_W'(1))};
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = mem_addr;
      op_d    = op;
      disp_d  = disp;
      two_d   = op_two;
      pc_d    = pc_out;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH_OP;
               addr_d  = inc12(pc_in);
            end
         end
         FETCH_OP: begin
            if (mem_ack) begin
               op_d = mem_rdata;
               if (mem_rdata[DW-1]) begin
                  two_d   = 1'b1;
                  addr_d  = inc12(mem_addr);
                  state_d = FETCH_DISP;
               end else begin
                  two_d   = 1'b0;
                  disp_d  = '0;
                  pc_d    = mem_addr;
                  state_d = DONE;
               end
            end
         end
         FETCH_DISP: begin
            if (mem_ack) begin
               disp_d  = mem_rdata;
               pc_d    = mem_addr;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      req_d  = (state_d == FETCH_OP) || (state_d == FETCH_DISP);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Outputs are registered copies of the next-state decode
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         op       <= '0;
         disp     <= '0;
         op_two   <= 1'b0;
         pc_out   <= '0;
         pc_we    <= 1'b0;
         op_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_req  <= req_d;
         mem_addr <= addr_d;
         op       <= op_d;
         disp     <= disp_d;
         op_two   <= two_d;
         pc_out   <= pc_d;
         pc_we    <= done_d;
         op_valid <= done_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_scmp_ifetch.sv
// Directed bench for scmp_ifetch: memory responder with wait states plus
// a scoreboard of expected fetch results popped on each op_valid.
module tb_scmp_ifetch;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] pc_in;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [7:0]  op;
   logic [7:0]  disp;
   logic        op_two;
   logic [15:0] pc_out;
   logic        pc_we;
   logic        op_valid;
   logic        busy;

   scmp_ifetch dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .pc_in    (pc_in),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .op       (op),
      .disp     (disp),
      .op_two   (op_two),
      .pc_out   (pc_out),
      .pc_we    (pc_we),
      .op_valid (op_valid),
      .busy     (busy)
   );

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  disp;
      logic        two;
      logic [15:0] pc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] addr_log[$];
   logic [7:0]  mem [0:65535];

   int          checks = 0;
   int          errors = 0;
   int          ov_count = 0;
   int          ws = 0;
   bit          resp_en = 0;
   bit          final_prev = 0;
   int          wait_cnt = 0;
   int          byte_idx = 0;
   logic [15:0] hold_addr = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor/scoreboard first (uses last cycle's flags), then memory responder
   initial begin
      forever begin
         @(negedge clk);
         if (op_valid === 1'b1) begin
            ov_count++;
            if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("op", op, e.op);
               check("disp", disp, e.disp);
               check("op_two", op_two, e.two);
               check("pc_out", pc_out, e.pc);
            end
         end
         if (op_valid === 1'b1 || pc_we === 1'b1) check("pc_we", pc_we, op_valid);
         if (final_prev || op_valid === 1'b1) check("ov_timing", op_valid, final_prev);
         final_prev = 1'b0;
         if (resp_en) begin
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
               if (wait_cnt >= ws) begin
                  mem_ack   = 1'b1;
                  mem_rdata = mem[mem_addr];
                  addr_log.push_back(mem_addr);
                  final_prev = (byte_idx == 1) || !mem_rdata[7];
                  byte_idx++;
                  wait_cnt = 0;
               end else begin
                  if (wait_cnt > 0) check("addr_stable", mem_addr, hold_addr);
                  hold_addr = mem_addr;
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
               byte_idx = 0;
            end
         end else begin
            wait_cnt = 0;
            byte_idx = 0;
         end
      end
   end

   task automatic fetch(input logic [15:0] pc, input int w, input logic [7:0] eop,
                        input logic [7:0] edisp, input logic etwo, input logic [15:0] epc,
                        input logic [15:0] a0, input logic [15:0] a1, input bit glitch);
      exp_t e;
      int   ov0;
      int   n;
      addr_log.delete();
      ws  = w;
      ov0 = ov_count;
      e.op = eop; e.disp = edisp; e.two = etwo; e.pc = epc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1;
      pc_in = pc;
      @(negedge clk);
      start = 1'b0;
      check("busy_start", busy, 1'b1);
      check("req_start", mem_req, 1'b1);
      check("addr_first", mem_addr, a0);
      if (glitch) begin
         start = 1'b1;
         pc_in = 16'h0700;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (op_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ov_timeout", op_valid, 1'b1);
      if (glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_end", busy, 1'b0);
      check("req_end", mem_req, 1'b0);
      repeat (3) @(negedge clk);
      check("busy_idle", busy, 1'b0);
      check("ov_once", 32'(ov_count), 32'(ov0 + 1));
      check("n_reads", 32'(addr_log.size()), etwo ? 32'd2 : 32'd1);
      if (addr_log.size() > 0) check("addr0", addr_log[0], a0);
      if (etwo && addr_log.size() > 1) check("addr1", addr_log[1], a1);
   endtask

   initial begin
      int n;
      int ov0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0001] = 8'h01;
      mem[16'h1234] = 8'hC4; mem[16'h1235] = 8'h55;
      mem[16'h2000] = 8'h90; mem[16'h2001] = 8'hFE;
      mem[16'h3000] = 8'h11;
      mem[16'h0401] = 8'hC0; mem[16'h0402] = 8'h12;
      mem[16'h0501] = 8'h07;
      mem[16'h0000] = 8'h3F;
      rst_n = 1'b0; start = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_rdata = '0;

      repeat (3) @(negedge clk);
      check("rst_req", mem_req, 1'b0);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_op", op, 8'h00);
      check("rst_disp", disp, 8'h00);
      check("rst_two", op_two, 1'b0);
      check("rst_pc", pc_out, 16'h0000);
      check("rst_we", pc_we, 1'b0);
      check("rst_ov", op_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n   = 1'b1;
      resp_en = 1'b1;

      fetch(16'h0000, 0, 8'h01, 8'h00, 1'b0, 16'h0001, 16'h0001, 16'h0000, 0);
      fetch(16'h1233, 0, 8'hC4, 8'h55, 1'b1, 16'h1235, 16'h1234, 16'h1235, 0);
      fetch(16'h2FFF, 0, 8'h90, 8'hFE, 1'b1, 16'h2001, 16'h2000, 16'h2001, 0);
      fetch(16'h0400, 3, 8'hC0, 8'h12, 1'b1, 16'h0402, 16'h0401, 16'h0402, 0);
      fetch(16'h0500, 2, 8'h07, 8'h00, 1'b0, 16'h0501, 16'h0501, 16'h0000, 1);

      // Reset while waiting on the displacement byte
      addr_log.delete();
      ws  = 5;
      ov0 = ov_count;
      @(negedge clk);
      start = 1'b1;
      pc_in = 16'h1233;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (addr_log.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach", 32'(n < 50), 32'd1);
      @(negedge clk);
      check("mid_op", op, 8'hC4);
      check("mid_addr", mem_addr, 16'h1235);
      check("mid_busy", busy, 1'b1);
      resp_en = 1'b0;
      mem_ack = 1'b0;
      rst_n   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_req", mem_req, 1'b0);
      check("mrst_busy", busy, 1'b0);
      check("mrst_op", op, 8'h00);
      check("mrst_pc", pc_out, 16'h0000);
      check("mrst_two", op_two, 1'b0);
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 8'h99;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_ov", 32'(ov_count), 32'(ov0));
      check("stray_busy", busy, 1'b0);
      check("stray_op", op, 8'h00);
      resp_en = 1'b1;

      fetch(16'h0FFF, 1, 8'h3F, 8'h00, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
